int_sched: RTL

Interrupt scheduler placed between the external interrupt sources and the CPU's single-interrupt PC-redirect logic. It synchronizes up to eight asynchronous interrupt lines and latches each rising edge as a pending bit. It applies a software-written mask, picks the highest-priority pending source and raises one request toward the CPU. It then holds that source as "in service" until the CPU's interrupt acknowledge and the subsequent eret complete the handshake.

---
 rtl/int_sched_if.sv | 27 ++
 rtl/int_sched.sv | 100 ++++++++++
 2 files changed

// File: rtl/int_sched_if.sv
// rtl/int_sched_if.sv - interrupt scheduler bus: irq lines, CPU handshake, register port
interface int_sched_if #(
  parameter int N_SRC = 8
);
  logic [N_SRC-1:0] irq_in;
  logic             int_ack;
  logic             eret;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [1:0]       rd_addr;
  logic [31:0]      rd_data;
  logic             int_req;
  logic [2:0]       int_id;
  logic [31:0]      int_vec;
  logic             busy;

  modport slave (
    input  irq_in, int_ack, eret, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, int_req, int_id, int_vec, busy
  );

  modport master (
    output irq_in, int_ack, eret, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, int_req, int_id, int_vec, busy
  );
endinterface

// File: rtl/int_sched.sv
// rtl/int_sched.sv - edge-latched, masked, fixed-priority interrupt scheduler
// with a single request/acknowledge/return handshake toward the CPU.
module int_sched #(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0004,
  parameter int          VEC_SHIFT = 3
) (
  input  logic         clk,
  input  logic         reset,
  int_sched_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       id_q, id_d;
  logic [N_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [N_SRC-1:0] pend_q, pend_d, mask_q;
  logic             gen_q;
  logic [N_SRC-1:0] edge_det, cand, w1c, ack_clr;
  logic [7:0]       cand8;
  logic [2:0]       win_id;
  logic             ack_take;

  assign edge_det = sync2_q & ~prev_q;
  assign cand     = gen_q ? (pend_q & mask_q) : '0;
  assign cand8    = 8'(cand);
  assign ack_take = bus.int_ack && (state_q == S_REQ);

  always_comb begin
    win_id  = '0;
    w1c     = '0;
    ack_clr = '0;
    // Scan downward so the lowest pending index is the one left in win_id.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win_id = 3'(i);
      w1c[i]     = bus.wr_en && (bus.wr_addr == 2'd1) && bus.wr_data[i];
      ack_clr[i] = ack_take && (id_q == 3'(i));
    end
    // A same-cycle edge outranks any clear of the same bit.
    pend_d = (pend_q & ~(w1c | ack_clr)) | edge_det;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (|cand) begin
          id_d    = win_id;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.int_ack)        state_d = S_SERVICE;
        else if (!cand8[id_q])  state_d = S_IDLE;
      end
      S_SERVICE: begin
        if (bus.eret) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      gen_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      sync1_q <= bus.irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
      if (bus.wr_en && bus.wr_addr == 2'd0) mask_q <= bus.wr_data[N_SRC-1:0];
      if (bus.wr_en && bus.wr_addr == 2'd3) gen_q  <= bus.wr_data[0];
    end
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.rd_addr)
      2'd0: bus.rd_data[N_SRC-1:0] = mask_q;
      2'd1: bus.rd_data[N_SRC-1:0] = pend_q;
      2'd2: bus.rd_data[4:0]       = {bus.busy, bus.int_req, id_q};
      default: bus.rd_data[0]      = gen_q;
    endcase
  end

  assign bus.int_req = (state_q == S_REQ);
  assign bus.busy    = (state_q == S_SERVICE);
  assign bus.int_id  = id_q;
  assign bus.int_vec = VEC_BASE + ({29'b0, id_q} << VEC_SHIFT);
endmodule
